code_keeper: RTL and testbench

//  Owns and writes the stored 4-digit combination that the lock comparator reads.

---
 rtl/code_keeper_pkg.sv | 40 ++++
 rtl/code_keeper_timer.sv | 30 +++
 rtl/code_keeper.sv | 157 +++++++++++++++
 tb/tb_code_keeper.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/code_keeper_pkg.sv
// Shared types and constants for the code-change dialogue: state encoding,
// display phase codes and the BCD digit check.
package lock_pkg;

  localparam int CODE_W = 16;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AUTH,
    ST_NEW1,
    ST_NEW2,
    ST_LOCKED
  } state_e;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_AUTH = 2'd1;
  localparam logic [1:0] PH_NEW1 = 2'd2;
  localparam logic [1:0] PH_NEW2 = 2'd3;

  function automatic logic is_bcd(input logic [CODE_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < CODE_W / 4; i++) begin
      if (v[4*i +: 4] > DIGIT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  // LOCKED shows the idle prompt; the locked output distinguishes it.
  function automatic logic [1:0] phase_of(input state_e s);
    case (s)
      ST_AUTH: return PH_AUTH;
      ST_NEW1: return PH_NEW1;
      ST_NEW2: return PH_NEW2;
      default: return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/code_keeper_timer.sv
// code_timer: saturating up-counter with synchronous clear and a terminal flag
// raised when the count equals the supplied limit.
module code_timer
  import lock_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [W-1:0] lim_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (cnt_q != {W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == lim_i);

endmodule

// File: rtl/code_keeper.sv
// code_keeper: owns the stored combination and runs the verify/new/confirm
// change dialogue. Define LOCKOUT_EN to enable the failed-attempt lockout.
module code_keeper
  import lock_pkg::*;
#(
  parameter logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int TIMEOUT_CYC = 2000,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYC    = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] entry,
  input  logic              entry_vld,
  input  logic              chg_req,
  input  logic              cancel,
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic [1:0]        phase,
  output logic              chg_ok,
  output logic              chg_err,
  output logic              locked
);

  localparam int TMAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d, tmp_q, tmp_d;
  logic              ok_q, ok_d, err_q, err_d;
  logic              busy_q, locked_q;
  logic [1:0]        phase_q;
  logic              in_dlg, tim_clr, tim_term;
  logic [TW-1:0]     tim_lim;

`ifdef LOCKOUT_EN
  localparam int TRW = $clog2(MAX_TRIES + 1);
  logic [TRW-1:0] tries_q, tries_d;
`endif

  assign in_dlg  = (state_q == ST_AUTH) || (state_q == ST_NEW1) || (state_q == ST_NEW2);
  // One counter serves both the dialogue timeout and the lockout hold.
  assign tim_lim = (state_q == ST_LOCKED) ? TW'(LOCK_CYC - 1) : TW'(TIMEOUT_CYC - 1);
  assign tim_clr = (state_d != state_q) || (entry_vld && in_dlg);

  code_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tim_clr),
    .lim_i  (tim_lim),
    .term_o (tim_term)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tmp_d   = tmp_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
`ifdef LOCKOUT_EN
    tries_d = tries_q;
`endif
    case (state_q)
      ST_IDLE: if (chg_req) state_d = ST_AUTH;
      ST_AUTH, ST_NEW1, ST_NEW2: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (entry_vld) begin
          if (state_q == ST_AUTH) begin
            if (entry == code_q) begin
              state_d = ST_NEW1;
`ifdef LOCKOUT_EN
              tries_d = '0;
`endif
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
`ifdef LOCKOUT_EN
              tries_d = tries_q + 1'b1;
              if (tries_q == TRW'(MAX_TRIES - 1)) state_d = ST_LOCKED;
`endif
            end
          end else if (state_q == ST_NEW1) begin
            if (is_bcd(entry)) begin
              tmp_d   = entry;
              state_d = ST_NEW2;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (entry == tmp_q) begin
              code_d  = tmp_q;
              ok_d    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_NEW1;
            end
          end
        end else if (tim_term) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (tim_term) begin
          state_d = ST_IDLE;
`ifdef LOCKOUT_EN
          tries_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      code_q   <= DEFAULT_CODE;
      tmp_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      phase_q  <= PH_IDLE;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      tmp_q    <= tmp_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      busy_q   <= (state_d != ST_IDLE);
      phase_q  <= phase_of(state_d);
      locked_q <= (state_d == ST_LOCKED);
    end
  end

`ifdef LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tries_q <= '0;
    else     tries_q <= tries_d;
  end
  assign locked = locked_q;
`else
  logic unused_locked;
  assign unused_locked = locked_q;
  assign locked = 1'b0;
`endif

  assign code    = code_q;
  assign busy    = busy_q;
  assign phase   = phase_q;
  assign chg_ok  = ok_q;
  assign chg_err = err_q;

endmodule

// File: tb/tb_code_keeper.sv
// Scoreboard bench for code_keeper: directed dialogue sequences push expected
// pulse responses; a negedge monitor pops and compares them.
module tb_code_keeper;

  localparam int TO = 40;
  localparam int LC = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] entry;
  logic        entry_vld, chg_req, cancel;
  logic [15:0] code;
  logic        busy, chg_ok, chg_err, locked;
  logic [1:0]  phase;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        ok;
    logic        err;
    logic [15:0] code;
    logic [1:0]  phase;
    logic        busy;
    logic        locked;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  code_keeper #(
    .DEFAULT_CODE (16'h1234),
    .TIMEOUT_CYC  (TO),
    .MAX_TRIES    (3),
    .LOCK_CYC     (LC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .entry     (entry),
    .entry_vld (entry_vld),
    .chg_req   (chg_req),
    .cancel    (cancel),
    .code      (code),
    .busy      (busy),
    .phase     (phase),
    .chg_ok    (chg_ok),
    .chg_err   (chg_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic ok, input logic err, input logic [15:0] c,
                              input logic [1:0] ph, input logic b, input logic lk);
    exp_t e;
    e.ok = ok; e.err = err; e.code = c; e.phase = ph; e.busy = b; e.locked = lk;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] v);
    @(posedge clk); #1 entry = v; entry_vld = 1'b1;
    @(posedge clk); #1 entry_vld = 1'b0;
  endtask

  task automatic req();
    @(posedge clk); #1 chg_req = 1'b1;
    @(posedge clk); #1 chg_req = 1'b0;
  endtask

  // Every chg_ok/chg_err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (chg_ok || chg_err)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: ok=%0b err=%0b, expected no pulse", chg_ok, chg_err);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_ok",     16'(chg_ok),  16'(mon_e.ok));
        chk("pulse_err",    16'(chg_err), 16'(mon_e.err));
        chk("pulse_code",   code,         mon_e.code);
        chk("pulse_phase",  16'(phase),   16'(mon_e.phase));
        chk("pulse_busy",   16'(busy),    16'(mon_e.busy));
        chk("pulse_locked", 16'(locked),  16'(mon_e.locked));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; entry = '0; entry_vld = 1'b0; chg_req = 1'b0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code",   code,            16'h1234);
    chk("rst_busy",   16'(busy),       16'd0);
    chk("rst_phase",  16'(phase),      16'd0);
    chk("rst_pulses", 16'({chg_ok, chg_err}), 16'd0);
    chk("rst_locked", 16'(locked),     16'd0);
    rst = 1'b0;

    // Full change 1234 -> 5678
    req();
    chk("auth_phase", 16'(phase), 16'd1);
    chk("auth_busy",  16'(busy),  16'd1);
    send(16'h1234);
    chk("new1_phase", 16'(phase), 16'd2);
    send(16'h5678);
    chk("new2_phase", 16'(phase), 16'd3);
    expect_pulse(1'b1, 1'b0, 16'h5678, 2'd0, 1'b0, 1'b0);
    send(16'h5678);
    @(negedge clk);
    chk("commit_code", code, 16'h5678);

    // Change back 5678 -> 1234
    req();
    send(16'h5678);
    send(16'h1234);
    expect_pulse(1'b1, 1'b0, 16'h1234, 2'd0, 1'b0, 1'b0);
    send(16'h1234);

    // Wrong AUTH code
    req();
    expect_pulse(1'b0, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b0);
    send(16'h0000);

    // NEW2 mismatch returns to NEW1, code untouched
    req();
    send(16'h1234);
    send(16'h5678);
    expect_pulse(1'b0, 1'b1, 16'h1234, 2'd2, 1'b1, 1'b0);
    send(16'h5679);

    // Non-BCD entry in NEW1 stays in NEW1
    expect_pulse(1'b0, 1'b1, 16'h1234, 2'd2, 1'b1, 1'b0);
    send(16'h12A4);
    chk("nonbcd_phase", 16'(phase), 16'd2);

    // cancel beats a valid entry in the same cycle
    @(posedge clk); #1 entry = 16'h5678; entry_vld = 1'b1; cancel = 1'b1;
    @(posedge clk); #1 entry_vld = 1'b0; cancel = 1'b0;
    chk("cancel_phase", 16'(phase), 16'd0);
    chk("cancel_busy",  16'(busy),  16'd0);
    chk("cancel_code",  code,       16'h1234);

    // chg_req with entry in IDLE: entry discarded, then AUTH timeout
    expect_pulse(1'b0, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1 entry = 16'h1234; entry_vld = 1'b1; chg_req = 1'b1;
    @(posedge clk); #1 entry_vld = 1'b0; chg_req = 1'b0;
    chk("reqent_phase", 16'(phase), 16'd1);
    repeat (TO - 2) @(posedge clk);
    #1 chk("pre_timeout_phase", 16'(phase), 16'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_phase", 16'(phase), 16'd0);
    chk("timeout_busy",  16'(busy),  16'd0);

`ifdef LOCKOUT_EN
    for (int i = 0; i < 3; i++) begin
      req();
      if (i < 2) expect_pulse(1'b0, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b0);
      else       expect_pulse(1'b0, 1'b1, 16'h1234, 2'd0, 1'b1, 1'b1);
      send(16'h9999);
    end
    chk("lock_locked", 16'(locked), 16'd1);
    req();
    chk("lock_req_ignored", 16'(phase), 16'd0);
    repeat (LC - 4) @(posedge clk);
    #1 chk("lock_hold", 16'(locked), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("unlock_locked", 16'(locked), 16'd0);
    chk("unlock_busy",   16'(busy),   16'd0);
    req();
    chk("unlock_req", 16'(phase), 16'd1);
    @(posedge clk); #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      req();
      expect_pulse(1'b0, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b0);
      send(16'h9999);
    end
    @(negedge clk);
    chk("nolock_locked", 16'(locked), 16'd0);
    req();
    chk("nolock_req", 16'(phase), 16'd1);
    @(posedge clk); #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
`endif

    repeat (5) @(posedge clk);
    #1 chk("sb_empty", 16'(sb.size()), 16'd0);
    chk("final_code", code, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
